// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: match-level sequencer for Pong.
// Takes single-cycle point pulses from the ball logic and keeps per-player BCD
// scores. Steps the match through idle, play, the pause between points and
// game over. Drives the ball logic's enable, recentre and serve direction.
//
// Ports:
//   clk, reset                 clock; reset is asynchronous and active-high
//   frame_tick                 one-cycle pulse per video frame
//   start                      debounced start level; only its rising edge matters
//   p1_point, p2_point         one-cycle rally-won pulses
//   play_en                    high only in PLAY
//   ball_recentre              one-cycle pulse on every entry to PLAY
//   serve_dir                  1 = serve toward player 2, 0 = toward player 1
//   p1_score_bcd, p2_score_bcd {tens, ones} BCD scores
//   winner                     00 none, 01 player 1, 10 player 2
//   state                      00 IDLE, 01 PLAY, 10 POINT, 11 OVER
//
// state | meaning
// IDLE  | after reset, scores cleared, waiting for start
// PLAY  | rally in progress, ball enabled
// POINT | pause between points, counting frame ticks
// OVER  | a player reached WIN_SCORE, scores frozen until start

module pong_match_ctrl #(
    parameter int WIN_SCORE    = 11,
    parameter int PAUSE_FRAMES = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       p1_point,
    input  logic       p2_point,
    output logic       play_en,
    output logic       ball_recentre,
    output logic       serve_dir,
    output logic [7:0] p1_score_bcd,
    output logic [7:0] p2_score_bcd,
    output logic [1:0] winner,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_PLAY  = 2'b01,
        S_POINT = 2'b10,
        S_OVER  = 2'b11
    } state_t;

    localparam logic [7:0] PAUSE_LAST = 8'(PAUSE_FRAMES - 1);
    localparam logic [6:0] WIN_BIN    = 7'(WIN_SCORE);

    state_t     state_q, state_next;
    logic       start_q, start_rise;
    logic [7:0] pause_cnt, pause_next;
    logic [6:0] p1_bin, p2_bin, p1_bin_next, p2_bin_next;
    logic [7:0] p1_bcd_next, p2_bcd_next;
    logic       serve_next;
    logic [1:0] winner_next;

    assign start_rise = start & ~start_q;
    assign state      = state_q;

    // ones digit wraps 9 -> 0 with a carry; 99 holds
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v == 8'h99)
            return v;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [6:0] bin_inc(input logic [6:0] v);
        return (v == 7'd99) ? v : v + 7'd1;
    endfunction

    always_comb begin
        state_next  = state_q;
        pause_next  = pause_cnt;
        p1_bin_next = p1_bin;
        p2_bin_next = p2_bin;
        p1_bcd_next = p1_score_bcd;
        p2_bcd_next = p2_score_bcd;
        serve_next  = serve_dir;
        winner_next = winner;
        case (state_q)
            S_IDLE: begin
                p1_bin_next = 7'd0;
                p2_bin_next = 7'd0;
                p1_bcd_next = 8'h00;
                p2_bcd_next = 8'h00;
                winner_next = 2'b00;
                if (start_rise) begin
                    serve_next = 1'b1;
                    state_next = S_PLAY;
                end
            end
            S_PLAY: begin
                // simultaneous pulses are treated as no decision
                if (p1_point ^ p2_point) begin
                    if (p1_point) begin
                        p1_bin_next = bin_inc(p1_bin);
                        p1_bcd_next = bcd_inc(p1_score_bcd);
                        serve_next  = 1'b1;
                    end else begin
                        p2_bin_next = bin_inc(p2_bin);
                        p2_bcd_next = bcd_inc(p2_score_bcd);
                        serve_next  = 1'b0;
                    end
                    pause_next = 8'd0;
                    state_next = S_POINT;
                end
            end
            S_POINT: begin
                if (frame_tick) begin
                    if (pause_cnt == PAUSE_LAST) begin
                        if (p1_bin == WIN_BIN) begin
                            winner_next = 2'b01;
                            state_next  = S_OVER;
                        end else if (p2_bin == WIN_BIN) begin
                            winner_next = 2'b10;
                            state_next  = S_OVER;
                        end else begin
                            state_next = S_PLAY;
                        end
                    end else begin
                        pause_next = pause_cnt + 8'd1;
                    end
                end
            end
            S_OVER: begin
                if (start_rise) begin
                    p1_bin_next = 7'd0;
                    p2_bin_next = 7'd0;
                    p1_bcd_next = 8'h00;
                    p2_bcd_next = 8'h00;
                    winner_next = 2'b00;
                    serve_next  = 1'b1;
                    state_next  = S_PLAY;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            start_q       <= 1'b0;
            pause_cnt     <= 8'd0;
            p1_bin        <= 7'd0;
            p2_bin        <= 7'd0;
            p1_score_bcd  <= 8'h00;
            p2_score_bcd  <= 8'h00;
            serve_dir     <= 1'b1;
            winner        <= 2'b00;
            play_en       <= 1'b0;
            ball_recentre <= 1'b0;
        end else begin
            state_q       <= state_next;
            start_q       <= start;
            pause_cnt     <= pause_next;
            p1_bin        <= p1_bin_next;
            p2_bin        <= p2_bin_next;
            p1_score_bcd  <= p1_bcd_next;
            p2_score_bcd  <= p2_bcd_next;
            serve_dir     <= serve_next;
            winner        <= winner_next;
            play_en       <= (state_next == S_PLAY);
            ball_recentre <= (state_next == S_PLAY) && (state_q != S_PLAY);
        end
    end

endmodule
